// File: rtl/mult_booth_pkg.sv
// rtl/mult_booth_pkg.sv - shared multiplier constants and FSM state encoding
// Contents:
//   WIDTH    operand width (32)
//   STEPS    Booth steps per multiply (32)
//   COUNT_W  width of the step counter (holds 0..STEPS)
//   state_t  IDLE=0, RUN=1, DONE=2
package mult_booth_pkg;

    localparam int WIDTH   = 32;
    localparam int STEPS   = 32;
    localparam int COUNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_booth_step.sv
// rtl/mult_booth_step.sv - one combinational radix-2 Booth step
// Module booth_step ports:
//   i_acc  [WIDTH:0]    accumulator (one guard bit so -M of 0x80000000 fits)
//   i_q    [WIDTH-1:0]  multiplier shift register Q
//   i_q_m1              Q-1 bit
//   i_m    [WIDTH-1:0]  latched multiplicand M
//   o_acc, o_q, o_q_m1  {acc,Q,Q-1} after add/sub and arithmetic right shift
module booth_step
    import mult_booth_pkg::*;
(
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q_m1,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q_m1
);

    logic [WIDTH:0] w_m_ext;
    logic [WIDTH:0] w_sum;

    assign w_m_ext = {i_m[WIDTH-1], i_m};

    always_comb begin
        w_sum = i_acc;
        case ({i_q[0], i_q_m1})
            2'b10:   w_sum = i_acc - w_m_ext;
            2'b01:   w_sum = i_acc + w_m_ext;
            default: w_sum = i_acc;
        endcase
    end

    // Arithmetic right shift of the concatenation {sum, Q, Q-1}.
    assign o_acc  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q    = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_q_m1 = i_q[0];

endmodule

// File: rtl/mult_booth.sv
// rtl/mult_booth.sv - sequential signed 32x32 radix-2 Booth multiplier
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset, priority over start
//   start          multiply request, sampled only in IDLE
//   a_in, b_in     signed multiplicand / multiplier, latched on acceptance
//   hi_out, lo_out upper / lower half of the 64-bit product, held between completions
//   busy           high in RUN
//   done           one-cycle pulse in DONE when hi_out/lo_out hold a new product
module mult_booth
    import mult_booth_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done
);

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q_m1;
    logic [WIDTH-1:0] r_m;
    logic [COUNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_acc;
    logic [WIDTH-1:0] w_q;
    logic             w_q_m1;

    booth_step u_step (
        .i_acc  (r_acc),
        .i_q    (r_q),
        .i_q_m1 (r_q_m1),
        .i_m    (r_m),
        .o_acc  (w_acc),
        .o_q    (w_q),
        .o_q_m1 (w_q_m1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Counter reaches zero after the last step; this edge only
                // publishes the product.
                if (r_count == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_q     <= '0;
            r_q_m1  <= 1'b0;
            r_m     <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m     <= a_in;
                        r_acc   <= '0;
                        r_q     <= b_in;
                        r_q_m1  <= 1'b0;
                        r_count <= COUNT_W'(STEPS);
                    end
                end
                RUN: begin
                    if (r_count != '0) begin
                        r_acc   <= w_acc;
                        r_q     <= w_q;
                        r_q_m1  <= w_q_m1;
                        r_count <= r_count - 1'b1;
                    end else begin
                        // Product is {acc[WIDTH-1:0], Q}; the guard bit only
                        // mirrors the sign at this point.
                        r_hi <= r_acc[WIDTH-1:0];
                        r_lo <= r_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule
